// File: rtl/dcmac200g_vl_marker_loader_if.sv
// AXI4-Lite write (and optional readback) channel bundle between the VL marker loader and the DCMAC interconnect.
// DCMAC_VL_LOADER_READBACK_EN adds the AR/R channels.
interface dcmac200g_vl_marker_loader_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] m_axi_awaddr;
  logic              m_axi_awvalid;
  logic              m_axi_awready;
  logic [31:0]       m_axi_wdata;
  logic [3:0]        m_axi_wstrb;
  logic              m_axi_wvalid;
  logic              m_axi_wready;
  logic [1:0]        m_axi_bresp;
  logic              m_axi_bvalid;
  logic              m_axi_bready;
`ifdef DCMAC_VL_LOADER_READBACK_EN
  logic [ADDR_W-1:0] m_axi_araddr;
  logic              m_axi_arvalid;
  logic              m_axi_arready;
  logic [31:0]       m_axi_rdata;
  logic [1:0]        m_axi_rresp;
  logic              m_axi_rvalid;
  logic              m_axi_rready;
`endif

  modport master (
    output m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid, m_axi_bready,
    input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid
`ifdef DCMAC_VL_LOADER_READBACK_EN
    , output m_axi_araddr, m_axi_arvalid, m_axi_rready
    , input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
`endif
  );

  modport slave (
    input  m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid, m_axi_bready,
    output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid
`ifdef DCMAC_VL_LOADER_READBACK_EN
    , input  m_axi_araddr, m_axi_arvalid, m_axi_rready
    , output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
`endif
  );
endinterface

// File: rtl/dcmac200g_vl_marker_loader.sv
// Snapshots the 20 TX VL marker IDs plus VL lengths on start and writes them as 41 AXI4-Lite words.
// Optional macro DCMAC_VL_LOADER_READBACK_EN reads each word back and compares it after its B response.
module dcmac200g_vl_marker_loader #(
  parameter int          ADDR_W        = 32,
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter logic [31:0] MARKER_OFFSET = 32'h0000_0400,
  parameter logic [31:0] VL_LEN_OFFSET = 32'h0000_04A0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [1279:0]                       vl_marker_ids,
  input  logic [15:0]                         vl_length_100ge,
  input  logic [15:0]                         vl_length_200ge_400ge,
  output logic                                busy,
  output logic                                done,
  output logic                                error,
  output logic [5:0]                          err_index,
  dcmac200g_vl_marker_loader_if.master        axi
);

  localparam logic [5:0] LAST_K = 6'd40;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP,
`ifdef DCMAC_VL_LOADER_READBACK_EN
    S_RD_ADDR,
    S_RD_DATA,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t            state, state_next;
  logic [5:0]        k;
  logic [5:0]        k_inc;
  logic              aw_done, w_done;
  logic [ADDR_W-1:0] awaddr;
  logic [31:0]       wdata;
  logic [1279:0]     snap_markers;
  logic [31:0]       snap_len;
  logic              load_first, advance, finish_ok, finish_err;
  logic              aw_hs, w_hs, b_hs;

  function automatic logic [ADDR_W-1:0] addr_for(input logic [5:0] idx);
    logic [31:0] a;
    if (idx == LAST_K) a = BASE_ADDR + VL_LEN_OFFSET;
    else               a = BASE_ADDR + MARKER_OFFSET + {24'd0, idx, 2'b00};
    return ADDR_W'(a);
  endfunction

  // Marker N's low/high halves are words 2N/2N+1, so word idx is simply bits [32*idx +: 32].
  function automatic logic [31:0] word_for(input logic [5:0] idx, input logic [1279:0] markers,
                                           input logic [31:0] len_word);
    if (idx == LAST_K) return len_word;
    return markers[{idx, 5'b00000} +: 32];
  endfunction

  assign aw_hs = axi.m_axi_awvalid & axi.m_axi_awready;
  assign w_hs  = axi.m_axi_wvalid  & axi.m_axi_wready;
  assign b_hs  = axi.m_axi_bvalid  & axi.m_axi_bready;
  assign k_inc = k + 6'd1;

`ifdef DCMAC_VL_LOADER_READBACK_EN
  logic ar_hs, r_hs;
  assign ar_hs              = axi.m_axi_arvalid & axi.m_axi_arready;
  assign r_hs               = axi.m_axi_rvalid  & axi.m_axi_rready;
  assign axi.m_axi_araddr   = awaddr;
  assign axi.m_axi_arvalid  = (state == S_RD_ADDR);
  assign axi.m_axi_rready   = (state == S_RD_DATA);
`endif

  assign axi.m_axi_awaddr  = awaddr;
  assign axi.m_axi_wdata   = wdata;
  assign axi.m_axi_wstrb   = 4'hF;
  assign axi.m_axi_awvalid = (state == S_ISSUE) & ~aw_done;
  assign axi.m_axi_wvalid  = (state == S_ISSUE) & ~w_done;
  assign axi.m_axi_bready  = (state == S_RESP);

  always_comb begin
    state_next = state;
    load_first = 1'b0;
    advance    = 1'b0;
    finish_ok  = 1'b0;
    finish_err = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_ISSUE;
          load_first = 1'b1;
        end
      end
      S_ISSUE: begin
        if ((aw_done | aw_hs) & (w_done | w_hs)) state_next = S_RESP;
      end
      S_RESP: begin
        if (b_hs) begin
          if (axi.m_axi_bresp != 2'b00) begin
            state_next = S_ERR;
            finish_err = 1'b1;
          end
`ifdef DCMAC_VL_LOADER_READBACK_EN
          else state_next = S_RD_ADDR;
`else
          else if (k == LAST_K) begin
            state_next = S_DONE;
            finish_ok  = 1'b1;
          end else begin
            state_next = S_ISSUE;
            advance    = 1'b1;
          end
`endif
        end
      end
`ifdef DCMAC_VL_LOADER_READBACK_EN
      S_RD_ADDR: begin
        if (ar_hs) state_next = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (r_hs) begin
          if ((axi.m_axi_rresp != 2'b00) || (axi.m_axi_rdata != wdata)) begin
            state_next = S_ERR;
            finish_err = 1'b1;
          end else if (k == LAST_K) begin
            state_next = S_DONE;
            finish_ok  = 1'b1;
          end else begin
            state_next = S_ISSUE;
            advance    = 1'b1;
          end
        end
      end
`endif
      S_DONE:  state_next = S_IDLE;
      S_ERR:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Status flips on the final response edge so done/error and the busy drop appear together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      k         <= 6'd0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_index <= 6'd0;
      awaddr    <= '0;
      wdata     <= 32'd0;
    end else begin
      state <= state_next;
      if ((state == S_ISSUE) && (state_next == S_ISSUE)) begin
        aw_done <= aw_done | aw_hs;
        w_done  <= w_done | w_hs;
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (load_first) begin
        busy      <= 1'b1;
        done      <= 1'b0;
        error     <= 1'b0;
        err_index <= 6'd0;
        k         <= 6'd0;
        awaddr    <= addr_for(6'd0);
        wdata     <= vl_marker_ids[31:0];
      end
      if (advance) begin
        k      <= k_inc;
        awaddr <= addr_for(k_inc);
        wdata  <= word_for(k_inc, snap_markers, snap_len);
      end
      if (finish_ok) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
      if (finish_err) begin
        busy      <= 1'b0;
        error     <= 1'b1;
        err_index <= k;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_first) begin
      snap_markers <= vl_marker_ids;
      snap_len     <= {vl_length_200ge_400ge, vl_length_100ge};
    end
  end

endmodule

// File: doc/dcmac200g_vl_marker_loader.md
Name: dcmac200g_vl_marker_loader

Overview:
Downstream consumer of the DCMAC 200G control-constant stage. On a start pulse it snapshots the 20 TX virtual-lane marker IDs and the two default VL-length values, then writes them into the DCMAC control register space through an AXI4-Lite write master. The block sits between the constant/control stage and the shell's AXI4-Lite interconnect toward the DCMAC, and reports busy, done and error status to the bring-up sequencer.

Parameters:
ADDR_W, 32, AXI4-Lite address width
BASE_ADDR, 32'h0000_0000, DCMAC control register base
MARKER_OFFSET, 32'h0000_0400, offset of marker word 0
VL_LEN_OFFSET, 32'h0000_04A0, offset of packed VL-length word

Ports:
clk  in  1  single clock for all logic
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle request to begin a load
vl_marker_ids  in  1280  marker N occupies bits [64N+63:64N], N=0..19
vl_length_100ge  in  16  default VL length for 100GE
vl_length_200ge_400ge  in  16  default VL length for 200GE/400GE
busy  out  1  high while a load is in progress
done  out  1  sticky; high after a successful load until the next accepted start
error  out  1  sticky; high after a failed load until the next accepted start
err_index  out  6  index of the failing write
m_axi_awaddr  out  ADDR_W  write address
m_axi_awvalid  out  1  write-address valid
m_axi_awready  in  1  write-address ready
m_axi_wdata  out  32  write data
m_axi_wstrb  out  4  write strobes; constant 4'hF
m_axi_wvalid  out  1  write-data valid
m_axi_wready  in  1  write-data ready
m_axi_bresp  in  2  write response
m_axi_bvalid  in  1  write-response valid
m_axi_bready  out  1  write-response ready

Behaviour:
- Reset values:
  - busy, done, error and all valid/ready outputs = 0.
  - err_index, awaddr and wdata = 0.
  - FSM = IDLE.
- Write sequence: 41 writes, k = 0..40.
  - k < 40: address BASE_ADDR + MARKER_OFFSET + 4k. Data is marker k>>1: bits [31:0] when k is even, bits [63:32] when k is odd.
  - k = 40: address BASE_ADDR + VL_LEN_OFFSET, data {vl_length_200ge_400ge, vl_length_100ge}.
- IDLE:
  - When start = 1, capture all inputs into snapshot registers.
  - Clear done, error and err_index; set busy; set k = 0; go to ISSUE.
- ISSUE:
  - Assert awvalid and wvalid together, with awaddr and wdata held stable.
  - Each valid drops independently on its own handshake; an aw_done or w_done flag records each handshake.
  - When both handshakes are done (same cycle or different cycles), go to RESP.
- RESP:
  - Assert bready.
  - On bvalid & bready with bresp = 2'b00: if k = 40, go to DONE; otherwise increment k and go to ISSUE.
  - On bvalid & bready with bresp != 0: set err_index = k and go to ERR.
- DONE: set done = 1, clear busy, go to IDLE.
- ERR: set error = 1, clear busy, go to IDLE. No further AW or W is issued.
- Latency with a zero-wait slave (awready = wready = 1, bvalid in the cycle RESP is entered):
  - start sampled at cycle T.
  - First awvalid at T+1.
  - Last B handshake at T+82.
  - done = 1 at T+83.
- Boundary conditions:
  - start while busy is ignored, and inputs are not re-snapshotted.
  - Input changes during a load have no effect.
  - rst mid-load returns every output to its reset value on the next edge. Any in-flight AXI transaction is abandoned, so the interconnect must be reset on the same rst.
  - bvalid seen outside RESP is not acknowledged (bready = 0).

Optional Feature:
Macro DCMAC_VL_LOADER_READBACK_EN.
- Defined:
  - Adds ports m_axi_araddr (out, ADDR_W), m_axi_arvalid (out, 1), m_axi_arready (in, 1), m_axi_rdata (in, 32), m_axi_rresp (in, 2), m_axi_rvalid (in, 1), m_axi_rready (out, 1).
  - After each successful B, the FSM enters RD_ADDR: it asserts arvalid with the same address until the AR handshake.
  - It then enters RD_DATA with rready = 1.
  - If rresp != 0 or rdata != the written word, set err_index = k and go to ERR. Otherwise continue to the next k or DONE.
  - Zero-wait latency becomes 4 cycles per write; done = 1 at T+165.
- Undefined: the AR/R ports and the RD states do not exist, and behaviour is as described above.

Test Plan:
- Nominal load, zero-wait slave, marker0 = 64'hc16821003e97de00, marker19 = 64'hc0f0e5003f0f1a00, lengths 255/256, default parameters:
  - write0 at 0x400 with data 0x3e97de00; write1 at 0x404 with data 0xc1682100.
  - write39 at 0x49C with data 0xc0f0e500; write40 at 0x4A0 with data 0x010000FF.
  - done = 1 at T+83, busy low.
- Random awready/wready/bvalid stalls, including AW accepted 3 cycles before W: each address/data stays stable until its own handshake, all 41 writes are in order, and no duplicate AW or W is issued.
- bresp = 2'b10 on write 5: error = 1, err_index = 5, done = 0, no further awvalid, and busy drops in the following cycle.
- start pulsed at write 10 with changed marker inputs: ignored, and all written data still matches the original snapshot.
- rst asserted during write 20 (AW accepted, B pending): the next cycle shows all outputs at reset values; a new start then completes 41 writes normally.
- Readback (macro defined), slave returns rdata 0x0 for write 2: error = 1, err_index = 2, no AW for write 3.
